// File: rtl/rgb_mixer_pkg.sv
// Shared constants and types for the three-channel RGB mixer.
package rgb_mixer_pkg;

    localparam int WIDTH        = 8;
    localparam int DEBOUNCE_LEN = 8;

    typedef logic [WIDTH-1:0] level_t;

endpackage

// File: rtl/rgb_channel.sv
// One mixer channel: encoder synchronise, debounce and decode into a level,
// then compare against the shared PWM counter.
module rgb_channel
    import rgb_mixer_pkg::*;
(
    input  logic   clock,
    input  logic   resetb,
    input  logic   enc_a,
    input  logic   enc_b,
    input  level_t count,
    output logic   pwm_out
);

    logic                    a_sync_p0, a_sync_p1;
    logic                    b_sync_p0, b_sync_p1;
    logic [DEBOUNCE_LEN-1:0] a_shr, b_shr;
    logic [DEBOUNCE_LEN-1:0] a_shr_next, b_shr_next;
    logic                    a_deb, b_deb;
    logic                    a_deb_prev;
    level_t                  level;

    // A debounced input flips only once its whole history agrees.
    function automatic logic deb_next(input logic [DEBOUNCE_LEN-1:0] hist,
                                      input logic cur);
        if (&hist)
            return 1'b1;
        if (~|hist)
            return 1'b0;
        return cur;
    endfunction

    // The newest sample is included in the decision so the debounced edge
    // lands DEBOUNCE_LEN clocks after the synchronised edge.
    always_comb begin
        a_shr_next = {a_shr[DEBOUNCE_LEN-2:0], a_sync_p1};
        b_shr_next = {b_shr[DEBOUNCE_LEN-2:0], b_sync_p1};
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            a_sync_p0  <= 1'b0;
            a_sync_p1  <= 1'b0;
            b_sync_p0  <= 1'b0;
            b_sync_p1  <= 1'b0;
            a_shr      <= '0;
            b_shr      <= '0;
            a_deb      <= 1'b0;
            b_deb      <= 1'b0;
            a_deb_prev <= 1'b0;
            level      <= '0;
            pwm_out    <= 1'b0;
        end else begin
            a_sync_p0  <= enc_a;
            a_sync_p1  <= a_sync_p0;
            b_sync_p0  <= enc_b;
            b_sync_p1  <= b_sync_p0;
            a_shr      <= a_shr_next;
            b_shr      <= b_shr_next;
            a_deb      <= deb_next(a_shr_next, a_deb);
            b_deb      <= deb_next(b_shr_next, b_deb);
            a_deb_prev <= a_deb;
            // Direction comes from B as seen in the cycle A rises; wraps naturally.
            if (a_deb && !a_deb_prev)
                level <= b_deb ? level - 1'b1 : level + 1'b1;
            pwm_out    <= (count < level);
        end
    end

endmodule

// File: rtl/rgb_mixer.sv
// Three-channel RGB mixer: shared free-running PWM counter feeding three
// encoder-controlled channels.
module rgb_mixer
    import rgb_mixer_pkg::*;
(
    input  logic clock,
    input  logic resetb,
    input  logic enc0_a,
    input  logic enc0_b,
    input  logic enc1_a,
    input  logic enc1_b,
    input  logic enc2_a,
    input  logic enc2_b,
    output logic pwm0_out,
    output logic pwm1_out,
    output logic pwm2_out
);

    level_t count;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    rgb_channel u_ch0 (
        .clock   (clock),
        .resetb  (resetb),
        .enc_a   (enc0_a),
        .enc_b   (enc0_b),
        .count   (count),
        .pwm_out (pwm0_out)
    );

    rgb_channel u_ch1 (
        .clock   (clock),
        .resetb  (resetb),
        .enc_a   (enc1_a),
        .enc_b   (enc1_b),
        .count   (count),
        .pwm_out (pwm1_out)
    );

    rgb_channel u_ch2 (
        .clock   (clock),
        .resetb  (resetb),
        .enc_a   (enc2_a),
        .enc_b   (enc2_b),
        .count   (count),
        .pwm_out (pwm2_out)
    );

endmodule

// File: tb/tb_rgb_mixer.sv
// Directed self-checking bench for rgb_mixer.
module tb_rgb_mixer;

    logic       clock;
    logic       resetb;
    logic [2:0] enc_a;
    logic [2:0] enc_b;
    logic       pwm0_out, pwm1_out, pwm2_out;

    int n_checks;
    int n_errors;

    rgb_mixer u_dut (
        .clock    (clock),
        .resetb   (resetb),
        .enc0_a   (enc_a[0]),
        .enc0_b   (enc_b[0]),
        .enc1_a   (enc_a[1]),
        .enc1_b   (enc_b[1]),
        .enc2_a   (enc_a[2]),
        .enc2_b   (enc_b[2]),
        .pwm0_out (pwm0_out),
        .pwm1_out (pwm1_out),
        .pwm2_out (pwm2_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // One clean detent on the masked channels: 12 clocks high, 12 low.
    task automatic step(input logic [2:0] mask);
        @(negedge clock);
        enc_a = enc_a | mask;
        repeat (12) @(negedge clock);
        enc_a = enc_a & ~mask;
        repeat (12) @(negedge clock);
    endtask

    task automatic measure(input int clocks, output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        repeat (clocks) begin
            @(posedge clock);
            #1;
            c0 += int'(pwm0_out);
            c1 += int'(pwm1_out);
            c2 += int'(pwm2_out);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetb = 1'b0;
        enc_a  = 3'b000;
        enc_b  = 3'b000;
        repeat (10) @(negedge clock);
        resetb = 1'b1;
    endtask

    int c0, c1, c2;

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetb   = 1'b0;
        enc_a    = 3'b000;
        enc_b    = 3'b000;

        // Reset and idle
        do_reset();
        chk("reset_pwm0_now", int'(pwm0_out), 0);
        measure(512, c0, c1, c2);
        chk("idle_pwm0", c0, 0);
        chk("idle_pwm1", c1, 0);
        chk("idle_pwm2", c2, 0);
        chk("idle_level0", int'(u_dut.u_ch0.level), 0);
        chk("idle_level1", int'(u_dut.u_ch1.level), 0);
        chk("idle_level2", int'(u_dut.u_ch2.level), 0);

        // 64 increments on channel 0
        repeat (64) step(3'b001);
        chk("inc_level0", int'(u_dut.u_ch0.level), 64);
        measure(256, c0, c1, c2);
        chk("inc_pwm0_duty", c0, 64);
        chk("inc_pwm1_idle", c1, 0);
        chk("inc_pwm2_idle", c2, 0);

        // One decrement on channel 1 from zero wraps to 255
        @(negedge clock);
        enc_b[1] = 1'b1;
        repeat (12) @(negedge clock);
        step(3'b010);
        enc_b[1] = 1'b0;
        repeat (12) @(negedge clock);
        chk("dec_level1", int'(u_dut.u_ch1.level), 255);
        measure(256, c0, c1, c2);
        chk("dec_pwm1_duty", c1, 255);
        chk("dec_pwm0_kept", c0, 64);

        // 256 increments on channel 2 wrap back to zero
        repeat (128) step(3'b100);
        chk("wrap_level2_mid", int'(u_dut.u_ch2.level), 128);
        repeat (128) step(3'b100);
        chk("wrap_level2", int'(u_dut.u_ch2.level), 0);
        measure(256, c0, c1, c2);
        chk("wrap_pwm2_duty", c2, 0);

        // Short glitches are rejected
        repeat (50) begin
            @(negedge clock);
            enc_a[0] = 1'b1;
            repeat (3) @(negedge clock);
            enc_a[0] = 1'b0;
            repeat (3) @(negedge clock);
        end
        repeat (12) @(negedge clock);
        chk("glitch_level0", int'(u_dut.u_ch0.level), 64);

        // Clean pulse: level moves exactly 11 clocks after the pad edge
        @(negedge clock);
        enc_a[0] = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("edge_level0_at10", int'(u_dut.u_ch0.level), 64);
        @(posedge clock);
        #1;
        chk("edge_level0_at11", int'(u_dut.u_ch0.level), 65);
        @(negedge clock);
        enc_a[0] = 1'b0;
        repeat (12) @(negedge clock);
        measure(256, c0, c1, c2);
        chk("edge_pwm0_duty", c0, 65);

        // All channels to 128, then a one-clock reset mid-run
        do_reset();
        chk("rst2_level1", int'(u_dut.u_ch1.level), 0);
        repeat (128) step(3'b111);
        chk("mid_level0", int'(u_dut.u_ch0.level), 128);
        chk("mid_level1", int'(u_dut.u_ch1.level), 128);
        chk("mid_level2", int'(u_dut.u_ch2.level), 128);
        measure(256, c0, c1, c2);
        chk("mid_pwm0_duty", c0, 128);
        chk("mid_pwm1_duty", c1, 128);
        chk("mid_pwm2_duty", c2, 128);

        // Land the reset while the outputs are high (counter just past 0)
        while (u_dut.count != 8'd1) begin
            @(posedge clock);
            #1;
        end
        chk("pre_rst_pwm0_high", int'(pwm0_out), 1);
        #2;
        resetb = 1'b0;
        #1;
        chk("async_pwm0", int'(pwm0_out), 0);
        chk("async_pwm1", int'(pwm1_out), 0);
        chk("async_pwm2", int'(pwm2_out), 0);
        @(posedge clock);
        @(negedge clock);
        resetb = 1'b1;
        measure(300, c0, c1, c2);
        chk("post_rst_pwm0", c0, 0);
        chk("post_rst_pwm1", c1, 0);
        chk("post_rst_pwm2", c2, 0);
        chk("post_rst_level0", int'(u_dut.u_ch0.level), 0);
        chk("post_rst_level2", int'(u_dut.u_ch2.level), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
